// File: rtl/data_mem_arbiter_if.sv
// Purpose: the two requester ports, the memory-side bus and the arbiter status outputs, bundled.
// Latency: none; this is wiring only.
// Backpressure: a requester holds req until its one-cycle ack, and port 0 also sees stall0.
interface data_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Port 0: CPU MEM stage
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic [DW-1:0] rdata0;
  logic          stall0;

  // Port 1: loader / debug
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata1;

  // Single-port data memory
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Status
  logic          busy;
  logic          grant_id;

  // Arbiter side
  modport slave (
    input  req0, we0, addr0, wdata0,
    output ack0, rdata0, stall0,
    input  req1, we1, addr1, wdata1,
    output ack1, rdata1,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, grant_id
  );

  // Requester and memory side
  modport master (
    output req0, we0, addr0, wdata0,
    input  ack0, rdata0, stall0,
    output req1, we1, addr1, wdata1,
    input  ack1, rdata1,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, grant_id
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Purpose: shares one single-port data memory between the CPU (port 0) and a loader/debug port (port 1).
// Latency: ack comes LATENCY+1 cycles after the IDLE sampling cycle, and the next grant can follow one IDLE cycle later.
// Backpressure: a port waits, holding req, until its ack; port 0 is fixed priority, but port 1 wins after STARVE_LIMIT losses.
module data_mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(LATENCY + 1);

  localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    r_state;
  logic [SW-1:0] r_streak;
  logic [CW-1:0] r_cnt;
  logic          r_gid;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic w_idle;
  logic w_req_any;
  logic w_pick1;
  logic w_grant;
  logic w_resp;
  logic w_ack0;
  logic w_ack1;

  assign w_idle    = (r_state == S_IDLE);
  assign w_req_any = bus.req0 | bus.req1;
  // Port 1 wins if it is alone, or if port 0 has used up its streak allowance.
  assign w_pick1   = bus.req1 & (~bus.req0 | (r_streak == LIMIT));
  assign w_grant   = w_idle & w_req_any;
  assign w_resp    = (r_state == S_RESP);
  assign w_ack0    = w_resp & ~r_gid;
  assign w_ack1    = w_resp & r_gid;

  // Access sequencer: IDLE -> ACCESS -> (WAIT while read data is in flight) -> RESP -> IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_cnt <= CNT_LOAD;
          if (LATENCY == 1) begin
            r_state <= S_RESP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Starvation counter: counts port-0 wins over a waiting port 1 and is cleared once port 1 is served or stops asking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak <= '0;
    end else if (w_idle) begin
      if (!bus.req1 || (w_grant && w_pick1)) begin
        r_streak <= '0;
      end else if (w_grant && (r_streak != LIMIT)) begin
        r_streak <= r_streak + SW'(1);
      end
    end
  end

  // Latch the granted request so the requester's bus is free to change after ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gid   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_gid   <= w_pick1;
      r_we    <= w_pick1 ? bus.we1    : bus.we0;
      r_addr  <= w_pick1 ? bus.addr1  : bus.addr0;
      r_wdata <= w_pick1 ? bus.wdata1 : bus.wdata0;
    end
  end

  // Memory strobe lasts exactly the ACCESS cycle; the write enable is qualified by it.
  assign bus.mem_en    = (r_state == S_ACCESS);
  assign bus.mem_we    = (r_state == S_ACCESS) & r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  // Read data is forwarded only during the owner's ack cycle, and is zero otherwise.
  assign bus.ack0   = w_ack0;
  assign bus.ack1   = w_ack1;
  assign bus.rdata0 = w_ack0 ? bus.mem_rdata : '0;
  assign bus.rdata1 = w_ack1 ? bus.mem_rdata : '0;

  // The CPU freezes from the cycle it raises req up to, but not including, its ack cycle.
  assign bus.stall0   = bus.req0 & ~w_ack0;
  assign bus.busy     = ~w_idle;
  assign bus.grant_id = r_gid;

  // Structural invariants of the sequencer
  a_we_needs_en: assert property (@(posedge clk) disable iff (!rst)
    bus.mem_we |-> bus.mem_en);
  a_single_ack: assert property (@(posedge clk) disable iff (!rst)
    !(w_ack0 && w_ack1));
  a_streak_range: assert property (@(posedge clk) disable iff (!rst)
    r_streak <= LIMIT);

endmodule
